// File: rtl/fx_pkg.sv
// fx_pkg: shared types and helpers for the fx_chain audio effect pipeline.
//   clip_mode_e   - clip stage mode encoding (2'b11 behaves as hard clip)
//   BYP_*         - bit positions inside the per-stage bypass vector
//   sat_s()       - clamp a wide signed value to a w-bit signed range
package fx_pkg;

  typedef enum logic [1:0] {
    CLIP_NONE     = 2'b00,
    CLIP_HARD     = 2'b01,
    CLIP_SOFT     = 2'b10,
    CLIP_HARD_ALT = 2'b11
  } clip_mode_e;

  localparam int BYP_HP   = 0;
  localparam int BYP_GAIN = 1;
  localparam int BYP_CLIP = 2;

  // Working width of sat_s; every caller sign-extends into this width.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] x,
                                                    input int w);
    logic signed [SAT_W-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)      sat_s = hi;
    else if (x < lo) sat_s = lo;
    else             sat_s = x;
  endfunction

endpackage

// File: rtl/fx_hipass.sv
// fx_hipass: one-pole DC-blocking highpass, one register of latency.
//   y = x - x_prev + y_prev - (y_prev >>> HP_SHIFT), saturated to FXP_SIZE.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   i_valid     - i_x holds a valid sample; state only advances on valid
//   i_bypass    - forward i_x unchanged (filter state keeps tracking)
//   i_x         - signed input sample
//   o_y         - registered signed output sample
module fx_hipass
  import fx_pkg::*;
#(
  parameter int FXP_SIZE = 16,
  parameter int HP_SHIFT = 6
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic                i_bypass,
  input  logic [FXP_SIZE-1:0] i_x,
  output logic [FXP_SIZE-1:0] o_y
);
  localparam int W = FXP_SIZE + 2;

  logic signed [FXP_SIZE-1:0] r_x_prev, r_y_prev, r_y;
  logic signed [FXP_SIZE-1:0] w_y_dec, w_y;
  logic signed [W-1:0]        w_sum;

  always_comb begin
    w_y_dec = r_y_prev >>> HP_SHIFT;
    // Two guard bits cover |x - x_prev| + |y_prev - leak| without wrap.
    w_sum = {{2{i_x[FXP_SIZE-1]}}, i_x}
          - {{2{r_x_prev[FXP_SIZE-1]}}, r_x_prev}
          + {{2{r_y_prev[FXP_SIZE-1]}}, r_y_prev}
          - {{2{w_y_dec[FXP_SIZE-1]}}, w_y_dec};
    w_y = FXP_SIZE'(sat_s({{(SAT_W-W){w_sum[W-1]}}, w_sum}, FXP_SIZE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_prev <= '0;
      r_y_prev <= '0;
      r_y      <= '0;
    end else if (i_valid) begin
      r_x_prev <= i_x;
      r_y_prev <= w_y;
      r_y      <= i_bypass ? i_x : w_y;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/fx_chain.sv
// fx_chain: 4-register effect pipeline: input -> highpass -> gain -> clip.
// Fixed latency of 4 cycles, one sample per cycle, no stall.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_par_gain    - target gain, unsigned, GAIN_FRAC fraction bits
//   i_mode        - clip mode (fx_pkg::clip_mode_e)
//   i_bypass      - per-stage bypass: [0] highpass, [1] gain, [2] clip
//   i_valid       - i_sample valid
//   i_sample      - signed input sample
//   o_valid       - o_sample valid (i_valid delayed 4 cycles)
//   o_sample      - signed output sample, held between valid outputs
//   o_clip        - output sample was clamped or saturated (0 when !o_valid)
//   o_gain_cur    - gain currently applied
// Build option: GAIN_RAMP_EN - gain steps 1 LSB per valid sample toward
// i_par_gain instead of loading it directly.
module fx_chain
  import fx_pkg::*;
#(
  parameter int FXP_SIZE  = 16,
  parameter int GAIN_W    = 11,
  parameter int GAIN_FRAC = 4,
  parameter int CLIP_BITS = 12,
  parameter int HP_SHIFT  = 6
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [GAIN_W-1:0]   i_par_gain,
  input  logic [1:0]          i_mode,
  input  logic [2:0]          i_bypass,
  input  logic                i_valid,
  input  logic [FXP_SIZE-1:0] i_sample,
  output logic                o_valid,
  output logic [FXP_SIZE-1:0] o_sample,
  output logic                o_clip,
  output logic [GAIN_W-1:0]   o_gain_cur
);
  localparam int STAGES = 4;
  localparam int PW     = FXP_SIZE + GAIN_W;
  localparam logic signed [PW-1:0] CLIP_L = PW'((64'sd1 <<< (CLIP_BITS - 1)) - 64'sd1);

  logic [STAGES-1:0]    r_vld_pipe;
  logic [FXP_SIZE-1:0]  r_x_in, w_hp, r_out;
  logic [GAIN_W-1:0]    r_g_cur, w_g_nxt;
  logic signed [PW:0]   w_hp_ext, w_g_ext, w_prod;
  logic signed [PW-1:0] r_gain_x, w_gain_x, w_abs, w_mag, w_cl;
  logic signed [SAT_W-1:0] w_cl64, w_sat;
  logic                 w_flag, r_clip;

  // Stage 1: input register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_x_in     <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-2:0], i_valid};
      if (i_valid) r_x_in <= i_sample;
    end
  end

  // Stage 2: highpass
  fx_hipass #(.FXP_SIZE(FXP_SIZE), .HP_SHIFT(HP_SHIFT)) u_hipass (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (r_vld_pipe[0]),
    .i_bypass (i_bypass[BYP_HP]),
    .i_x      (r_x_in),
    .o_y      (w_hp)
  );

  // Stage 3: gain. The product uses the gain value being registered this
  // cycle, so o_gain_cur always names the gain of the latest sample.
  always_comb begin
`ifdef GAIN_RAMP_EN
    w_g_nxt = r_g_cur;
    if (r_g_cur < i_par_gain)      w_g_nxt = r_g_cur + GAIN_W'(1);
    else if (r_g_cur > i_par_gain) w_g_nxt = r_g_cur - GAIN_W'(1);
`else
    w_g_nxt = i_par_gain;
`endif
    w_hp_ext = {{(PW + 1 - FXP_SIZE){w_hp[FXP_SIZE-1]}}, w_hp};
    w_g_ext  = {{(PW + 1 - GAIN_W){1'b0}}, w_g_nxt};
    w_prod   = w_hp_ext * w_g_ext;
    if (i_bypass[BYP_GAIN]) w_gain_x = {{GAIN_W{w_hp[FXP_SIZE-1]}}, w_hp};
    else                    w_gain_x = PW'(w_prod >>> GAIN_FRAC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g_cur  <= '0;
      r_gain_x <= '0;
    end else if (r_vld_pipe[1]) begin
      r_g_cur  <= w_g_nxt;
      r_gain_x <= w_gain_x;
    end
  end

  // Stage 4: clip, then saturate to full scale
  always_comb begin
    w_cl   = r_gain_x;
    w_flag = 1'b0;
    w_abs  = r_gain_x[PW-1] ? -r_gain_x : r_gain_x;
    w_mag  = CLIP_L + ((w_abs - CLIP_L) >>> 2);
    if (!i_bypass[BYP_CLIP]) begin
      case (i_mode)
        CLIP_NONE: ;
        CLIP_SOFT: if (w_abs > CLIP_L) begin
          w_cl   = r_gain_x[PW-1] ? -w_mag : w_mag;
          w_flag = 1'b1;
        end
        default: if (r_gain_x > CLIP_L) begin
          w_cl   = CLIP_L;
          w_flag = 1'b1;
        end else if (r_gain_x < -CLIP_L) begin
          w_cl   = -CLIP_L;
          w_flag = 1'b1;
        end
      endcase
    end
    w_cl64 = {{(SAT_W - PW){w_cl[PW-1]}}, w_cl};
    w_sat  = sat_s(w_cl64, FXP_SIZE);
    if (w_sat != w_cl64) w_flag = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_clip <= 1'b0;
    end else begin
      r_clip <= r_vld_pipe[2] & w_flag;
      if (r_vld_pipe[2]) r_out <= w_sat[FXP_SIZE-1:0];
    end
  end

  assign o_valid    = r_vld_pipe[STAGES-1];
  assign o_sample   = r_out;
  assign o_clip     = r_clip;
  assign o_gain_cur = r_g_cur;

endmodule

// File: tb/tb_fx_chain.sv
// tb_fx_chain: directed-vector bench for fx_chain with hand-computed results.
// Honours GAIN_RAMP_EN when the design is built with it.
module tb_fx_chain;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] i_par_gain;
  logic [1:0]  i_mode;
  logic [2:0]  i_bypass;
  logic        i_valid;
  logic [15:0] i_sample;
  logic        o_valid;
  logic [15:0] o_sample;
  logic        o_clip;
  logic [10:0] o_gain_cur;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fx_chain dut (
    .clk        (clk),
    .rst        (rst),
    .i_par_gain (i_par_gain),
    .i_mode     (i_mode),
    .i_bypass   (i_bypass),
    .i_valid    (i_valid),
    .i_sample   (i_sample),
    .o_valid    (o_valid),
    .o_sample   (o_sample),
    .o_clip     (o_clip),
    .o_gain_cur (o_gain_cur)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic rst_dut();
    rst = 1'b1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // n back-to-back zero samples, then drain the pipe
  task automatic warm(input int n);
    i_sample = '0;
    i_valid  = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    i_valid  = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
  endtask

  // one sample; lat = edges from the sampling edge to o_valid (16 = timeout)
  task automatic run1(input int s, output int lat);
    i_sample = s[15:0];
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid  = 1'b0;
    lat = 1;
    while (!o_valid && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [10:0] g;
    logic [1:0]  m;
    logic [2:0]  b;
    int          s;
    int          e;
    int          c;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

`ifdef GAIN_RAMP_EN
  localparam int WARM_N = 2100;
`else
  localparam int WARM_N = 2;
`endif

  initial begin
    int lat, n_out, bad, prev, cur, second, seen;

    vt[0]  = '{11'h020, 2'b01, 3'b101,   3000,   6000, 0};  // gain 2.0
    vt[1]  = '{11'h010, 2'b01, 3'b001,   5000,   2047, 1};  // hard
    vt[2]  = '{11'h010, 2'b10, 3'b001,   5000,   2785, 1};  // soft
    vt[3]  = '{11'h010, 2'b01, 3'b001,  -5000,  -2047, 1};
    vt[4]  = '{11'h010, 2'b10, 3'b001,  -5000,  -2785, 1};
    vt[5]  = '{11'h010, 2'b11, 3'b001,   5000,   2047, 1};  // mode 3 = hard
    vt[6]  = '{11'h010, 2'b01, 3'b001,   2047,   2047, 0};  // exactly L
    vt[7]  = '{11'h010, 2'b10, 3'b001,   2048,   2047, 1};  // soft just over L
    vt[8]  = '{11'h010, 2'b00, 3'b001,   5000,   5000, 0};  // no clip
    vt[9]  = '{11'h010, 2'b01, 3'b101,   5000,   5000, 0};  // clip bypass
    vt[10] = '{11'h7FF, 2'b00, 3'b001,  30000,  32767, 1};  // saturate +
    vt[11] = '{11'h7FF, 2'b00, 3'b001, -30000, -32768, 1};  // saturate -
    vt[12] = '{11'h018, 2'b00, 3'b001,     -3,     -5, 0};  // -72>>>4 floors
    vt[13] = '{11'h000, 2'b01, 3'b011,   5000,   2047, 1};  // gain bypass

    i_par_gain = 11'h010;
    i_mode     = 2'b01;
    i_bypass   = 3'b111;
    i_sample   = '0;
    i_valid    = 1'b0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_sample", int'(o_sample), 0);
    chk("rst_clip", int'(o_clip), 0);
    chk("rst_gain", int'(o_gain_cur), 0);
    rst = 1'b0;

    // full bypass: passthrough, latency, hold
    run1(1234, lat);
    chk("byp_lat", lat, 4);
    chk("byp_out", $signed(o_sample), 1234);
    chk("byp_clip", int'(o_clip), 0);
    @(posedge clk); #1;
    chk("hold_valid", int'(o_valid), 0);
    chk("hold_out", $signed(o_sample), 1234);
    chk("hold_clip", int'(o_clip), 0);

    // highpass only: DC step decays toward the floor of the leak term
    rst_dut();
    i_bypass = 3'b110;
    i_mode   = 2'b00;
    n_out = 0; bad = 0; prev = 0; second = 0;
    for (int k = 0; k < 2010; k++) begin
      i_sample = 16'd1000;
      i_valid  = (k < 2000);
      @(posedge clk); #1;
      if (o_valid) begin
        cur = $signed(o_sample);
        if (n_out == 0) chk("hp_first", cur, 1000);
        else if (cur > prev) bad++;
        if (n_out == 1) second = cur;
        prev = cur;
        n_out++;
      end
    end
    i_valid = 1'b0;
    chk("hp_count", n_out, 2000);
    chk("hp_second", second, 985);
    chk("hp_mono_viol", bad, 0);
    chk("hp_final", prev, 63);

    // gain / clip vectors
    for (int v = 0; v < NV; v++) begin
      rst_dut();
      i_par_gain = vt[v].g;
      i_mode     = vt[v].m;
      i_bypass   = vt[v].b;
      warm(WARM_N);
      run1(vt[v].s, lat);
      chk($sformatf("v%0d_lat", v), lat, 4);
      chk($sformatf("v%0d_out", v), $signed(o_sample), vt[v].e);
      chk($sformatf("v%0d_clip", v), int'(o_clip), vt[v].c);
    end

    // gain register behaviour
    rst_dut();
    i_bypass   = 3'b111;
    i_par_gain = 11'h010;
`ifdef GAIN_RAMP_EN
    warm(15);
    chk("ramp_15", int'(o_gain_cur), 15);
    warm(1);
    chk("ramp_16", int'(o_gain_cur), 16);
    warm(10);
    chk("ramp_hold", int'(o_gain_cur), 16);
    i_par_gain = 11'h00E;
    warm(1);
    chk("ramp_down", int'(o_gain_cur), 15);
`else
    warm(1);
    chk("gain_load", int'(o_gain_cur), 16);
    i_par_gain = 11'h005;
    warm(1);
    chk("gain_reload", int'(o_gain_cur), 5);
`endif

    // reset with three samples in flight
    i_bypass   = 3'b111;
    i_par_gain = 11'h010;
    run1(777, lat);
    chk("pre_rst_out", $signed(o_sample), 777);
    for (int k = 0; k < 3; k++) begin
      i_sample = 16'(100 + k);
      i_valid  = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("flt_valid", int'(o_valid), 0);
    chk("flt_sample", int'(o_sample), 0);
    chk("flt_clip", int'(o_clip), 0);
    chk("flt_gain", int'(o_gain_cur), 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    chk("flt_no_valid", seen, 0);
    run1(-321, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_out", $signed(o_sample), -321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fx_chain.md
FX_CHAIN -- requirements
Module: fx_chain

Interface
REQ-001 SHALL have parameter FXP_SIZE, default 16, meaning signed sample width.
REQ-002 SHALL have parameter GAIN_W, default 11, meaning unsigned gain width.
REQ-003 SHALL have parameter GAIN_FRAC, default 4, meaning fractional bits of gain.
REQ-004 SHALL have parameter CLIP_BITS, default 12, meaning clip level L = 2^(CLIP_BITS-1)-1.
REQ-005 SHALL have parameter HP_SHIFT, default 6, meaning highpass pole a = 1-2^-HP_SHIFT.
REQ-006 SHALL have port clk, input, 1, meaning sole clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port i_par_gain, input, GAIN_W, meaning target gain, unsigned fixed point with GAIN_FRAC fraction bits.
REQ-009 SHALL have port i_mode, input, 2, meaning clip mode: 00 none, 01 hard, 10 soft, 11 treated as hard.
REQ-010 SHALL have port i_bypass, input, 3, meaning per-stage bypass: bit0 highpass, bit1 gain, bit2 clip.
REQ-011 SHALL have port i_valid, input, 1, meaning i_sample valid this cycle.
REQ-012 SHALL have port i_sample, input, FXP_SIZE, meaning signed input sample.
REQ-013 SHALL have port o_valid, input-derived output, 1, meaning o_sample valid.
REQ-014 SHALL have port o_sample, output, FXP_SIZE, meaning signed output sample.
REQ-015 SHALL have port o_clip, output, 1, meaning the current output sample was clipped or saturated; qualified by o_valid.
REQ-016 SHALL have port o_gain_cur, output, GAIN_W, meaning the gain currently applied.

Function
REQ-017 SHALL be a 4-register pipeline (input, highpass, gain, clip); o_valid SHALL equal i_valid delayed exactly 4 cycles; no stall, one sample per cycle accepted.
REQ-018 SHALL update the highpass state and gain ramp only on cycles where the corresponding stage holds a valid sample.
REQ-019 Highpass SHALL compute y = x - x_prev + y_prev - (y_prev >>> HP_SHIFT) in FXP_SIZE+2 bits and saturate to FXP_SIZE signed.
REQ-020 Gain stage SHALL compute (x * g_cur) >>> GAIN_FRAC in full-width signed arithmetic and carry FXP_SIZE+GAIN_W bits to the clip stage.
REQ-021 Hard clip SHALL clamp to [-L, +L]; soft clip SHALL output sign*(L + (|x|-L)>>2) for |x|>L; both SHALL then saturate to FXP_SIZE full scale.
REQ-022 Mode 00 or clip bypass SHALL only saturate to FXP_SIZE full scale; o_clip SHALL flag any clamp or saturation.
REQ-023 A bypassed stage SHALL pass data unchanged through its register, latency unchanged; bypassed highpass SHALL keep updating its state.
REQ-024 Gain bypass SHALL pass the highpass output sign-extended (gain 1.0).
REQ-025 i_mode and i_bypass SHALL be sampled per stage when that stage's valid sample is registered.
REQ-026 Invalid cycles SHALL hold o_sample at its last value; o_clip SHALL be 0 when o_valid is 0.

Reset
REQ-027 rst SHALL clear all pipeline valids, data registers, highpass state, and g_cur to 0; o_valid, o_sample, o_clip, o_gain_cur SHALL read 0 in the cycle after rst is high.
REQ-028 Samples in flight at reset SHALL be discarded; the first output after reset SHALL appear 4 cycles after the first post-reset i_valid.

Configuration
REQ-029 With GAIN_RAMP_EN defined, g_cur SHALL step 1 LSB toward i_par_gain per valid sample at the gain stage, holding when equal.
REQ-030 Without GAIN_RAMP_EN, g_cur SHALL load i_par_gain directly on each valid sample at the gain stage.

Structure
REQ-031 Package fx_pkg SHALL hold the clip-mode enum, the bypass bit-index constants, and a signed saturate function.
REQ-032 The highpass SHALL be the sub-module fx_hipass (valid-gated, parameters FXP_SIZE and HP_SHIFT); the remaining stages stay in fx_chain.

Verification
REQ-033 Bypass 3'b111 and i_sample=1234 valid -> o_sample=1234, o_valid 4 cycles later, o_clip=0.
REQ-034 HP only, DC step of 1000 held for 2000 valid samples -> first output 1000; output decays monotonically to |o|<=64.
REQ-035 Gain 0x020 (2.0) with GAIN_RAMP_EN undefined, HP/clip bypassed, input 3000 -> output 6000.
REQ-036 Hard clip, gain 0x010, input 5000 -> 2047, o_clip=1; soft clip -> 2047+(5000-2047)/4=2785, o_clip=1.
REQ-037 GAIN_RAMP_EN defined, reset, target 0x010, continuous valid -> o_gain_cur reaches 16 after 16 samples and holds.
REQ-038 Assert rst with 3 samples in flight -> no o_valid for those samples; all outputs 0 the next cycle.
